// File: rtl/out_port_pkg.sv
// Shared definitions for the buffered output-port controller: FSM state
// encoding, default geometry and a constant-evaluable log2 helper.
package out_port_pkg;

  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    ACTIVE = 2'd1,
    FULL   = 2'd2
  } state_e;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_DEPTH      = 4;

  // Smallest r such that 2**r >= value; used to size FIFO pointers.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 << i) < value) begin
        result = i + 1;
      end else begin
        result = result;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/out_port_fifo.sv
// Storage for the output port: circular buffer with separate read/write
// pointers and an occupancy counter one bit wider than the pointers so that
// full and empty are never ambiguous. The head entry is presented
// combinationally from registered storage (first-word fall-through).
module out_port_fifo
  import out_port_pkg::*;
#(
  parameter  int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter  int DEPTH      = DEF_DEPTH,
  localparam int ADDR_W     = clog2(DEPTH)
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic                  i_push,
  input  logic                  i_pop,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  output logic [DATA_WIDTH-1:0] o_head,
  output logic [ADDR_W:0]       o_count
);

  localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);
  localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W + 1)'(1);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_W-1:0]     r_rd_ptr;
  logic [ADDR_W-1:0]     r_wr_ptr;
  logic [ADDR_W:0]       r_count;

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      if (i_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Data storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clock) begin
    if (i_push) begin
      r_mem[r_wr_ptr] <= i_wr_data;
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/out_port_ctrl.sv
// Buffered output-port controller. Bus writes are queued in a small FIFO and
// handed to the device over valid/ready; out_port holds the last accepted
// word. Handshake outputs decode only from the registered FSM state, so no
// input reaches an output combinationally.
module out_port_ctrl
  import out_port_pkg::*;
#(
  parameter  int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter  int DEPTH      = DEF_DEPTH,
  localparam int ADDR_W     = clog2(DEPTH)
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic                  OutPortin,
  input  logic [DATA_WIDTH-1:0] BusMuxOut,
  output logic                  out_busy,
  output logic [DATA_WIDTH-1:0] dev_data,
  output logic                  dev_valid,
  input  logic                  dev_ready,
  output logic [DATA_WIDTH-1:0] out_port,
  output logic [ADDR_W:0]       count,
  output logic                  overflow,
  input  logic                  ovf_clr
);

  localparam logic [ADDR_W:0] CNT_ONE     = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W:0] CNT_ALMOST  = (ADDR_W + 1)'(DEPTH - 1);

  state_e                r_state;
  state_e                w_state_nxt;
  logic [DATA_WIDTH-1:0] r_out_port;
  logic                  r_overflow;
  logic [DATA_WIDTH-1:0] w_head;
  logic [ADDR_W:0]       w_count;
  logic [DATA_WIDTH-1:0] w_dev_data;
  logic                  w_dev_valid;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_drop;

  // A full buffer still accepts a write when the head leaves the same cycle.
  assign w_dev_valid = (r_state != EMPTY);
  assign w_pop       = w_dev_valid & dev_ready;
  assign w_push      = OutPortin & ((r_state != FULL) | w_pop);
  assign w_drop      = OutPortin & (r_state == FULL) & ~w_pop;

  out_port_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_fifo (
    .clock     (clock),
    .clear     (clear),
    .i_push    (w_push),
    .i_pop     (w_pop),
    .i_wr_data (BusMuxOut),
    .o_head    (w_head),
    .o_count   (w_count)
  );

  // FSM state register.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic tracking occupancy class; push+pop leaves state alone.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      EMPTY: begin
        if (w_push) w_state_nxt = ACTIVE;
        else        w_state_nxt = EMPTY;
      end
      ACTIVE: begin
        if (w_push && !w_pop && (w_count == CNT_ALMOST))      w_state_nxt = FULL;
        else if (w_pop && !w_push && (w_count == CNT_ONE))    w_state_nxt = EMPTY;
        else                                                  w_state_nxt = ACTIVE;
      end
      FULL: begin
        if (w_pop && !w_push) w_state_nxt = ACTIVE;
        else                  w_state_nxt = FULL;
      end
      default: w_state_nxt = EMPTY;
    endcase
  end

  // Head data is only meaningful while something is buffered.
  always_comb begin
    w_dev_data = '0;
    if (r_state != EMPTY) begin
      w_dev_data = w_head;
    end else begin
      w_dev_data = '0;
    end
  end

  // Capture the word the device takes.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      r_out_port <= '0;
    end else if (w_pop) begin
      r_out_port <= w_dev_data;
    end
  end

  // Sticky drop flag; a new drop wins over a same-cycle clear request.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end else if (ovf_clr) begin
      r_overflow <= 1'b0;
    end
  end

  assign dev_valid = w_dev_valid;
  assign out_busy  = (r_state == FULL);
  assign dev_data  = w_dev_data;
  assign out_port  = r_out_port;
  assign count     = w_count;
  assign overflow  = r_overflow;

endmodule
